reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer feeding the retire stage.
- Allocates one entry per dispatched instruction and records writeback results from the CDB.
- Presents the oldest entry as rob_head and pops it when retire asserts rob_decrement.
- A flush discards all in-flight entries.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two, at least 2.
- TAG_W, $clog2(ROB_SIZE), width of entry tag/index.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- dispatch_en  input  1  request to allocate one entry
- dispatch_entry  input  rob_entry  payload (rd, ctrl_bits); ready/value fields ignored
- dispatch_tag  output  TAG_W  slot index granted (tail pointer)
- rob_full  output  1  count == ROB_SIZE
- rob_empty  output  1  count == 0
- rob_count  output  TAG_W+1  occupied entries
- cdb_valid  input  1  completion broadcast
- cdb_tag  input  TAG_W  completing slot
- cdb_value  input  MemoryWord  result value
- rob_head  output  rob_entry  oldest entry; all-zero when empty
- rob_decrement  input  1  retire pops head
- flush  input  1  discard all entries

Behaviour:
- Reset (synchronous, active-high):
  - head, tail and count go to 0; every slot's valid and ready clear.
  - Outputs after reset: rob_empty=1, rob_full=0, rob_count=0, dispatch_tag=0, rob_head=0.
- Dispatch:
  - Accepted iff dispatch_en && !rob_full && !flush.
  - Slot[tail] gets dispatch_entry with valid=1, ready=0, value=0.
  - tail advances mod ROB_SIZE.
  - dispatch_tag is the combinational current tail, valid in the request cycle.
  - Dispatch while full is dropped silently; no state change.
- Completion:
  - cdb_valid with slot[cdb_tag].valid=1 sets ready=1 and value=cdb_value on the next edge.
  - CDB to an invalid slot is ignored.
  - Repeat CDB to an already-ready slot overwrites value.
- Head:
  - rob_head = slot[head] combinationally from registered state.
  - Forced to all-zero when rob_empty.
- Retire:
  - Honoured iff rob_decrement && !rob_empty && slot[head].ready && !flush.
  - Clears slot[head].valid/ready; head advances mod ROB_SIZE.
  - rob_decrement while head is not ready or the buffer is empty is ignored.
- Simultaneous dispatch and retire: both take effect and count is unchanged.
  - Full buffer: dispatch is blocked, so count decrements.
  - One-entry buffer: head and tail move together.
- Flush:
  - Highest priority; next edge behaves exactly like reset.
  - Dispatch, CDB and retire in the flush cycle are discarded.
- Wrap-around: pointers are TAG_W bits and roll over naturally; full/empty come from count, not pointer compare.
- Latency:
  - Dispatch to visible-as-head is 1 cycle.
  - CDB to rob_head.ready is 1 cycle (without the optional feature).

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: when cdb_valid && cdb_tag==head && slot[head].valid, rob_head shows ready=1 and value=cdb_value in the same cycle, so retire can fire that cycle. The registered write still occurs and is harmless if the slot is popped the same edge (pop wins, slot cleared).
- Undefined: no forwarding; one-cycle CDB-to-head delay.

Decomposition:
- Shared package holds:
  - rob_entry struct: valid, ready, rd (Register), value (MemoryWord), ctrl_bits.
  - Register, MemoryWord and ctrl_bits typedefs.
  - ROB_SIZE default constant.
- Sub-module rob_ptr_ctr: TAG_W-bit wrapping pointer with increment and synchronous clear; instantiated for head and tail.

Test Plan:
- Reset, then dispatch 3 entries (rd=5,6,7) -> dispatch_tag 0,1,2; rob_count=3; rob_head.rd=5, ready=0.
- CDB tag1=0xDEAD, then tag0=0xBEEF, with rob_decrement held high:
  - Head retires tag0 (0xBEEF), then tag1 (0xDEAD) on consecutive cycles.
  - Tag2 stays at head with ready=0; count=1.
- Dispatch 16 entries -> rob_full=1. 17th dispatch is dropped (count stays 16, tail=0). Retire+dispatch in the same cycle while full -> count=15.
- Stream 20 dispatch/complete/retire -> dispatch_tag wraps 15->0; retired rd order matches dispatch order; rob_empty=1 at end.
- 5 entries in flight, flush asserted with dispatch_en=1 -> next cycle rob_count=0, rob_empty=1, rob_head=0, dispatched entry absent.
- ROB_BYPASS_EN defined: CDB to head tag with value 0x1234 -> rob_head.ready=1, value=0x1234 in the same cycle. Undefined -> visible one cycle later.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: register/data typedefs, the entry
// record and the default buffer depth.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEFAULT = 16;
  localparam int REG_W            = 5;
  localparam int WORD_W           = 32;
  localparam int CTRL_W           = 4;

  typedef logic [REG_W-1:0]  Register;
  typedef logic [WORD_W-1:0] MemoryWord;
  typedef logic [CTRL_W-1:0] CtrlBits;

  typedef struct packed {
    logic      valid;
    logic      ready;
    Register   rd;
    MemoryWord value;
    CtrlBits   ctrl_bits;
  } rob_entry;

  // Turns a dispatch request into a freshly allocated slot: the payload is
  // kept, the bookkeeping fields are forced to "allocated, not yet complete".
  function automatic rob_entry make_alloc_entry(input rob_entry req);
    rob_entry e;
    e       = req;
    e.valid = 1'b1;
    e.ready = 1'b0;
    e.value = '0;
    return e;
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctr.sv
// Wrapping pointer used for the reorder buffer head and tail. The width is a
// power-of-two index, so rollover falls out of plain binary overflow.
module rob_ptr_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Clear (reset or flush) dominates; otherwise step by one when asked.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Allocates at the tail on dispatch, marks
// entries complete from the CDB, presents the oldest entry as rob_head and
// pops it on rob_decrement. Flush behaves like a synchronous reset.
// Optional macro ROB_BYPASS_EN forwards a CDB hit on the head slot straight
// onto rob_head in the same cycle so it can retire without waiting a cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_en,
  input  rob_entry         dispatch_entry,
  output logic [TAG_W-1:0] dispatch_tag,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [TAG_W:0]   rob_count,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  MemoryWord        cdb_value,
  output rob_entry         rob_head,
  input  logic             rob_decrement,
  input  logic             flush
);

  rob_entry         slots [ROB_SIZE];
  logic [TAG_W-1:0] head_ptr;
  logic [TAG_W-1:0] tail_ptr;
  logic [TAG_W:0]   count;
  logic             dispatch_fire;
  logic             retire_fire;
  rob_entry         alloc_entry;
  rob_entry         head_view;

  assign rob_full     = (count == (TAG_W+1)'(ROB_SIZE));
  assign rob_empty    = (count == '0);
  assign rob_count    = count;
  assign dispatch_tag = tail_ptr;
  assign rob_head     = head_view;

  assign dispatch_fire = dispatch_en && !rob_full && !flush;
  assign retire_fire   = rob_decrement && !rob_empty && head_view.ready && !flush;

  // Normalise the incoming payload into an allocated-but-incomplete slot.
  always_comb begin
    alloc_entry = make_alloc_entry(dispatch_entry);
  end

  // Oldest entry as seen by retire; optionally forwards a same-cycle CDB hit,
  // and reads as all-zero whenever nothing is in flight.
  always_comb begin
    head_view = slots[head_ptr];
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_tag == head_ptr) && head_view.valid) begin
      head_view.ready = 1'b1;
      head_view.value = cdb_value;
    end
`endif
    if (rob_empty) begin
      head_view = '0;
    end
  end

  rob_ptr_ctr #(.W(TAG_W)) u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (retire_fire),
    .ptr   (head_ptr)
  );

  rob_ptr_ctr #(.W(TAG_W)) u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (dispatch_fire),
    .ptr   (tail_ptr)
  );

  // Occupancy tracks dispatch minus retire; full/empty derive from it so the
  // equal-pointer case is never ambiguous.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({dispatch_fire, retire_fire})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot storage: completion first, then allocation, then retire clear, so a
  // pop of the head wins over a same-edge CDB write to that slot.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        slots[i].valid <= 1'b0;
        slots[i].ready <= 1'b0;
      end
    end else begin
      if (cdb_valid && slots[cdb_tag].valid) begin
        slots[cdb_tag].ready <= 1'b1;
        slots[cdb_tag].value <= cdb_value;
      end
      if (dispatch_fire) begin
        slots[tail_ptr] <= alloc_entry;
      end
      if (retire_fire) begin
        slots[head_ptr].valid <= 1'b0;
        slots[head_ptr].ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Directed stimulus pushes the
// expected retire stream into a queue; a monitor pops and compares every time
// the buffer presents a retiring head. Honours ROB_BYPASS_EN.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = 4;

  typedef struct {
    Register   rd;
    MemoryWord value;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             dispatch_en;
  rob_entry         dispatch_entry;
  logic [TAG_W-1:0] dispatch_tag;
  logic             rob_full;
  logic             rob_empty;
  logic [TAG_W:0]   rob_count;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  MemoryWord        cdb_value;
  rob_entry         rob_head;
  logic             rob_decrement;
  logic             flush;

  exp_t expQ[$];
  exp_t monExp;
  int   testsRun    = 0;
  int   testsFailed = 0;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .dispatch_en    (dispatch_en),
    .dispatch_entry (dispatch_entry),
    .dispatch_tag   (dispatch_tag),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .rob_count      (rob_count),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .rob_head       (rob_head),
    .rob_decrement  (rob_decrement),
    .flush          (flush)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input Register rd, input logic [TAG_W-1:0] expTag,
                               input MemoryWord plannedValue, input bit expAccept);
    dispatch_en             = 1'b1;
    dispatch_entry          = '0;
    dispatch_entry.rd       = rd;
    dispatch_entry.ctrl_bits = rd[3:0];
    dispatch_entry.ready    = 1'b1;
    dispatch_entry.value    = 32'hFFFF_FFFF;
    #1;
    checkOutput("dispatch_tag", 32'(dispatch_tag), 32'(expTag));
    if (expAccept) expQ.push_back('{rd, plannedValue});
    stepCycle();
    dispatch_en = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    dispatch_en    = 1'b0;
    dispatch_entry = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_value      = '0;
    rob_decrement  = 1'b0;
    flush          = 1'b0;

    fork
      // Retire monitor: whenever the head is about to pop, compare it with
      // the oldest expected entry.
      forever begin
        @(negedge clk);
        if (!reset && !flush && rob_decrement && !rob_empty && rob_head.ready) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL retire_unexpected: got rd 0x%0h, expected no retire", rob_head.rd);
          end else begin
            monExp = expQ.pop_front();
            checkOutput("retire_rd", 32'(rob_head.rd), 32'(monExp.rd));
            checkOutput("retire_value", rob_head.value, monExp.value);
          end
        end
      end
      begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    repeat (2) stepCycle();
    reset = 1'b0;

    // Reset state.
    checkOutput("reset_empty", 32'(rob_empty), 1);
    checkOutput("reset_full", 32'(rob_full), 0);
    checkOutput("reset_count", 32'(rob_count), 0);
    checkOutput("reset_tag", 32'(dispatch_tag), 0);
    checkOutput("reset_head_zero", 32'(rob_head != '0), 0);

    // Three dispatches, head shows the first one not yet complete.
    applyStimulus(5'd5, 4'd0, 32'hBEEF, 1'b1);
    applyStimulus(5'd6, 4'd1, 32'hDEAD, 1'b1);
    applyStimulus(5'd7, 4'd2, 32'h7777, 1'b1);
    checkOutput("count_3", 32'(rob_count), 3);
    checkOutput("head_rd_5", 32'(rob_head.rd), 5);
    checkOutput("head_ready_0", 32'(rob_head.ready), 0);
    checkOutput("head_value_0", rob_head.value, 0);
    checkOutput("head_ctrl", 32'(rob_head.ctrl_bits), 5);

    // Out-of-order completion with retire held high.
    rob_decrement = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'hDEAD;
    stepCycle();
    cdb_tag = 4'd0; cdb_value = 32'hBEEF;
    stepCycle();
    cdb_valid = 1'b0;
    repeat (2) stepCycle();
    rob_decrement = 1'b0;
    checkOutput("after_retire_count", 32'(rob_count), 1);
    checkOutput("after_retire_head_rd", 32'(rob_head.rd), 7);
    checkOutput("after_retire_head_ready", 32'(rob_head.ready), 0);

    // Complete and retire the last one; buffer drains with pointers at 3.
    rob_decrement = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h7777;
    stepCycle();
    cdb_valid = 1'b0;
    stepCycle();
    rob_decrement = 1'b0;
    checkOutput("drain_empty", 32'(rob_empty), 1);
    checkOutput("drain_tag", 32'(dispatch_tag), 3);

    // Fill to full, then a dropped dispatch.
    for (int i = 0; i < 16; i++) applyStimulus(Register'(i), TAG_W'(3 + i), 32'h100 + i, 1'b1);
    checkOutput("full_flag", 32'(rob_full), 1);
    checkOutput("full_count", 32'(rob_count), 16);
    applyStimulus(5'h1F, 4'd3, 32'h0, 1'b0);
    checkOutput("drop_count", 32'(rob_count), 16);
    checkOutput("drop_tag", 32'(dispatch_tag), 3);
    checkOutput("drop_head_rd", 32'(rob_head.rd), 0);

    // Retire plus dispatch while full: only the retire happens.
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h100;
    stepCycle();
    cdb_valid = 1'b0;
    dispatch_en = 1'b1; dispatch_entry = '0; dispatch_entry.rd = 5'h1E;
    rob_decrement = 1'b1;
    stepCycle();
    dispatch_en = 1'b0; rob_decrement = 1'b0;
    checkOutput("full_retire_count", 32'(rob_count), 15);
    checkOutput("full_retire_flag", 32'(rob_full), 0);

    // Drain the remaining 15 in order.
    rob_decrement = 1'b1;
    for (int i = 1; i < 16; i++) begin
      cdb_valid = 1'b1; cdb_tag = TAG_W'(3 + i); cdb_value = 32'h100 + i;
      stepCycle();
    end
    cdb_valid = 1'b0;
    repeat (3) stepCycle();
    rob_decrement = 1'b0;
    checkOutput("full_drain_empty", 32'(rob_empty), 1);

    // Streaming dispatch/complete/retire across the tag wrap.
    rob_decrement = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dispatch_en = 1'b1; dispatch_entry = '0; dispatch_entry.rd = Register'(i + 8);
      cdb_valid = (i > 0);
      cdb_tag   = TAG_W'(3 + i - 1);
      cdb_value = 32'h2000 + i - 1;
      #1;
      checkOutput("stream_tag", 32'(dispatch_tag), 32'((3 + i) % 16));
      expQ.push_back('{Register'(i + 8), 32'h2000 + i});
      stepCycle();
    end
    dispatch_en = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h2013;
    stepCycle();
    cdb_valid = 1'b0;
    repeat (3) stepCycle();
    rob_decrement = 1'b0;
    checkOutput("stream_empty", 32'(rob_empty), 1);
    checkOutput("stream_tag_end", 32'(dispatch_tag), 7);

    // Flush with five in flight and a competing dispatch/CDB/retire.
    for (int i = 0; i < 5; i++) applyStimulus(Register'(20 + i), TAG_W'(7 + i), 32'h0, 1'b1);
    checkOutput("preflush_count", 32'(rob_count), 5);
    expQ.delete();
    flush = 1'b1; dispatch_en = 1'b1; dispatch_entry = '0; dispatch_entry.rd = 5'h1E;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'hAAAA; rob_decrement = 1'b1;
    stepCycle();
    flush = 1'b0; dispatch_en = 1'b0; cdb_valid = 1'b0; rob_decrement = 1'b0;
    checkOutput("flush_count", 32'(rob_count), 0);
    checkOutput("flush_empty", 32'(rob_empty), 1);
    checkOutput("flush_head_zero", 32'(rob_head != '0), 0);
    checkOutput("flush_tag", 32'(dispatch_tag), 0);
    stepCycle();
    checkOutput("flush_absent_count", 32'(rob_count), 0);

    // CDB-to-head latency and value overwrite.
    applyStimulus(5'd3, 4'd0, 32'h5678, 1'b1);
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h1234;
    #1;
`ifdef ROB_BYPASS_EN
    checkOutput("cdb_same_cycle_ready", 32'(rob_head.ready), 1);
    checkOutput("cdb_same_cycle_value", rob_head.value, 32'h1234);
`else
    checkOutput("cdb_same_cycle_ready", 32'(rob_head.ready), 0);
    checkOutput("cdb_same_cycle_value", rob_head.value, 32'h0);
`endif
    stepCycle();
    cdb_value = 32'h5678;
    #1;
    checkOutput("cdb_next_ready", 32'(rob_head.ready), 1);
`ifdef ROB_BYPASS_EN
    checkOutput("cdb_next_value", rob_head.value, 32'h5678);
`else
    checkOutput("cdb_next_value", rob_head.value, 32'h1234);
`endif
    stepCycle();
    cdb_valid = 1'b0;
    #1;
    checkOutput("cdb_overwrite_value", rob_head.value, 32'h5678);
    rob_decrement = 1'b1;
    stepCycle();
    rob_decrement = 1'b0;
    checkOutput("final_empty", 32'(rob_empty), 1);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
